// File: rtl/ahb_master_seq_if.sv
// AHB master-side signal bundle for ahb_master_seq: arbitration, address/control, data.
interface ahb_master_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              HBUSREQ;
  logic              HGRANT;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [DATA_W-1:0] HRDATA;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;

  modport master (
    output HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HGRANT, HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HGRANT, HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_master_seq.sv
// Command-FIFO to AHB sequencer: pops beats, drives pipelined INCR word bursts, rewinds on RETRY/SPLIT.
// Optional read-data capture is enabled by defining AHB_MSEQ_RDATA_EN.
module ahb_master_seq #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       fifo_empty,
  input  logic [ADDR_W+DATA_W+2:0]   fifo_dataout,
  output logic                       fifo_readen,
  output logic                       fifo_tail_back,
  output logic [4:0]                 fifo_back_length,
  ahb_master_seq_if.master           bus,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       err_pulse,
  output logic                       busy
);
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W + 3;
  localparam int unsigned B_LAST  = ENTRY_W - 1;
  localparam int unsigned B_FIRST = ENTRY_W - 2;
  localparam int unsigned B_WRITE = ENTRY_W - 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RESP2} state_e;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
  typedef enum logic [1:0] {RSP_OKAY = 2'b00, RSP_ERROR = 2'b01, RSP_RETRY = 2'b10, RSP_SPLIT = 2'b11} hresp_e;

  state_e             state_q, state_d;
  logic               bypass_q;
  logic               hold_v_q;
  logic [ENTRY_W-1:0] hold_q;
  logic               last_q;
  logic               first_q;
  logic               dp_v_q;
  logic               dp_write_q;
  logic [DATA_W-1:0]  hwdata_q;
  logic               err_q;

  logic [ENTRY_W-1:0] cur_beat;
  logic               cur_v;
  logic               cur_last;
  logic               prev_last;
  logic               resp_bad1;
  logic               rewind1;
  logic               accept;
  logic [1:0]         inflight;
  logic               unused_bits;

  // The slot is the freshly popped FIFO word when one arrived this cycle, else the hold register.
  assign cur_beat  = bypass_q ? fifo_dataout : hold_q;
  assign cur_v     = bypass_q | hold_v_q;
  assign cur_last  = cur_beat[B_LAST];
  assign prev_last = bypass_q ? fifo_dataout[B_LAST] : last_q;
  assign resp_bad1 = dp_v_q & ~bus.HREADY & (bus.HRESP != RSP_OKAY);
  assign rewind1   = dp_v_q & ~bus.HREADY &
                     ((bus.HRESP == RSP_RETRY) | (bus.HRESP == RSP_SPLIT));
  assign accept    = (state_q == S_XFER) & cur_v & bus.HREADY & bus.HGRANT;
  assign inflight  = {1'b0, cur_v} + {1'b0, dp_v_q};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.HBUSREQ    = 1'b0;
    bus.HTRANS     = HT_IDLE;
    fifo_tail_back = 1'b0;
    fifo_readen    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rewind1)                      state_d = S_RESP2;
        else if (!fifo_empty || hold_v_q) state_d = S_REQ;
      end
      S_REQ: begin
        bus.HBUSREQ = 1'b1;
        if (rewind1)                          state_d = S_RESP2;
        else if (bus.HGRANT && bus.HREADY)    state_d = S_XFER;
      end
      S_XFER: begin
        bus.HBUSREQ = 1'b1;
        if (cur_v && !rewind1) bus.HTRANS = first_q ? HT_NONSEQ : HT_SEQ;
        if (rewind1)                          state_d = S_RESP2;
        else if (bus.HREADY && !bus.HGRANT)   state_d = S_REQ;
        else if (accept && cur_last)          state_d = S_IDLE;
      end
      S_RESP2: begin
        bus.HBUSREQ    = 1'b1;
        fifo_tail_back = 1'b1;
        state_d        = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_q == S_REQ || state_q == S_XFER) && !fifo_empty && !resp_bad1 &&
        !prev_last && (!cur_v || accept))
      fifo_readen = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bypass_q   <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b1;
      dp_v_q     <= 1'b0;
      dp_write_q <= 1'b0;
      hwdata_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      bypass_q <= fifo_readen;
      err_q    <= dp_v_q & ~bus.HREADY & (bus.HRESP == RSP_ERROR);
      first_q  <= (state_q != S_XFER) ? 1'b1 : (accept ? 1'b0 : first_q);
      if (state_q == S_RESP2 || (accept && cur_last)) last_q <= 1'b0;
      else if (bypass_q)                              last_q <= fifo_dataout[B_LAST];
      // Rewind discards both the slot and the pending data phase; the FIFO replays them.
      if (state_q == S_RESP2) begin
        hold_v_q <= 1'b0;
        dp_v_q   <= 1'b0;
      end else begin
        hold_v_q <= cur_v & ~accept;
        if (cur_v && !accept) hold_q <= cur_beat;
        if (bus.HREADY) begin
          dp_v_q <= accept;
          if (accept) begin
            dp_write_q <= cur_beat[B_WRITE];
            hwdata_q   <= cur_beat[DATA_W-1:0];
          end
        end
      end
    end
  end

  assign bus.HADDR        = cur_v ? cur_beat[DATA_W +: ADDR_W] : '0;
  assign bus.HWRITE       = cur_v & cur_beat[B_WRITE];
  assign bus.HWDATA       = hwdata_q;
  assign bus.HSIZE        = 3'b010;
  assign bus.HBURST       = 3'b001;
  assign fifo_back_length = {3'b000, inflight};
  assign err_pulse        = err_q;
  assign busy             = (state_q != S_IDLE) | (inflight != 2'd0);

`ifdef AHB_MSEQ_RDATA_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= dp_v_q & bus.HREADY & ~dp_write_q & (bus.HRESP == RSP_OKAY);
      if (dp_v_q && bus.HREADY && !dp_write_q && bus.HRESP == RSP_OKAY)
        rd_data <= bus.HRDATA;
    end
  end
  assign unused_bits = cur_beat[B_FIRST];
`else
  assign rd_valid    = 1'b0;
  assign rd_data     = '0;
  assign unused_bits = ^{cur_beat[B_FIRST], dp_write_q, bus.HRDATA};
`endif
endmodule

// File: tb/tb_ahb_master_seq.sv
// Directed bench for ahb_master_seq: table-driven write burst plus hand-written response/grant/reset cases.
module tb_ahb_master_seq;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        fifo_empty, fifo_readen, fifo_tail_back;
  logic [66:0] fifo_dataout;
  logic [4:0]  fifo_back_length;
  logic [31:0] rd_data;
  logic        rd_valid, err_pulse, busy;

  always #5 HCLK = ~HCLK;

  ahb_master_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
    .fifo_readen(fifo_readen), .fifo_tail_back(fifo_tail_back),
    .fifo_back_length(fifo_back_length), .bus(bus), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_pulse(err_pulse), .busy(busy)
  );

  // Command FIFO model: registered read port, tail rewind, pointers cleared by HRESETn.
  logic [66:0] mem [0:31];
  logic [4:0]  tail;
  logic [4:0]  wr_cnt = 5'd0;
  int          pops = 0;
  assign fifo_empty = (tail >= wr_cnt);

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tail <= 5'd0;
      fifo_dataout <= '0;
    end else if (fifo_tail_back) begin
      tail <= tail - fifo_back_length;
    end else if (fifo_readen) begin
      fifo_dataout <= mem[tail];
      tail <= tail + 5'd1;
    end
  end

  always @(posedge HCLK) if (HRESETn && fifo_readen) pops <= pops + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [66:0] ent(input bit last, input bit first, input bit wr,
                                      input logic [31:0] a, input logic [31:0] d);
    return {last, first, wr, a, d};
  endfunction

  task automatic drive(input bit g, input bit r, input logic [1:0] resp, input logic [31:0] rdat);
    bus.HGRANT = g;
    bus.HREADY = r;
    bus.HRESP  = resp;
    bus.HRDATA = rdat;
    #2;
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".busreq"}, 32'(bus.HBUSREQ), 32'd0);
    chk({t, ".htrans"}, 32'(bus.HTRANS), 32'd0);
    chk({t, ".haddr"},  bus.HADDR, 32'd0);
    chk({t, ".hwrite"}, 32'(bus.HWRITE), 32'd0);
    chk({t, ".hwdata"}, bus.HWDATA, 32'd0);
    chk({t, ".hsize"},  32'(bus.HSIZE), 32'd2);
    chk({t, ".hburst"}, 32'(bus.HBURST), 32'd1);
    chk({t, ".readen"}, 32'(fifo_readen), 32'd0);
    chk({t, ".tback"},  32'(fifo_tail_back), 32'd0);
    chk({t, ".blen"},   32'(fifo_back_length), 32'd0);
    chk({t, ".rdv"},    32'(rd_valid), 32'd0);
    chk({t, ".rdd"},    rd_data, 32'd0);
    chk({t, ".err"},    32'(err_pulse), 32'd0);
    chk({t, ".busy"},   32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    wr_cnt  = 5'd0;
    bus.HGRANT = 1'b1;
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = '0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic load_wburst();
    for (int i = 0; i < 4; i++)
      mem[i] = ent(i == 3, i == 0, 1'b1, 32'h1000 + 32'(4 * i), 32'hA000_0001 + 32'(i));
    wr_cnt = 5'd4;
  endtask

  typedef struct {
    bit          g, r;
    bit [1:0]    resp;
    bit          e_rd, e_req, e_wr, e_busy;
    bit [1:0]    e_tr;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  function automatic vec_t mkv(input bit g, input bit r, input bit [1:0] resp, input bit e_rd,
                               input bit e_req, input bit e_wr, input bit e_busy,
                               input bit [1:0] e_tr, input logic [31:0] e_addr,
                               input logic [31:0] e_wdata);
    vec_t v;
    v.g = g; v.r = r; v.resp = resp;
    v.e_rd = e_rd; v.e_req = e_req; v.e_wr = e_wr; v.e_busy = e_busy;
    v.e_tr = e_tr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    return v;
  endfunction

  vec_t tv [8];
  int   p0;
  logic exp_rv;
  logic [31:0] exp_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while HRESETn is held low.
    bus.HGRANT = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = '0;
    #12;
    chk_reset("rst");

    // 4-beat write burst at 0x1000 with grant and ready held high.
    tv[0] = mkv(1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 32'h0,    32'h0);
    tv[1] = mkv(1, 1, 2'b00, 1, 1, 0, 1, 2'b00, 32'h0,    32'h0);
    tv[2] = mkv(1, 1, 2'b00, 1, 1, 1, 1, 2'b10, 32'h1000, 32'h0);
    tv[3] = mkv(1, 1, 2'b00, 1, 1, 1, 1, 2'b11, 32'h1004, 32'hA000_0001);
    tv[4] = mkv(1, 1, 2'b00, 1, 1, 1, 1, 2'b11, 32'h1008, 32'hA000_0002);
    tv[5] = mkv(1, 1, 2'b00, 0, 1, 1, 1, 2'b11, 32'h100C, 32'hA000_0003);
    tv[6] = mkv(1, 1, 2'b00, 0, 0, 0, 1, 2'b00, 32'h0,    32'hA000_0004);
    tv[7] = mkv(1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 32'h0,    32'hA000_0004);
    do_reset();
    load_wburst();
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].g, tv[i].r, tv[i].resp, 32'h0);
      chk($sformatf("wb%0d.readen", i), 32'(fifo_readen), 32'(tv[i].e_rd));
      chk($sformatf("wb%0d.busreq", i), 32'(bus.HBUSREQ), 32'(tv[i].e_req));
      chk($sformatf("wb%0d.htrans", i), 32'(bus.HTRANS), 32'(tv[i].e_tr));
      chk($sformatf("wb%0d.haddr", i), bus.HADDR, tv[i].e_addr);
      chk($sformatf("wb%0d.hwrite", i), 32'(bus.HWRITE), 32'(tv[i].e_wr));
      chk($sformatf("wb%0d.hwdata", i), bus.HWDATA, tv[i].e_wdata);
      chk($sformatf("wb%0d.busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("wb%0d.tback", i), 32'(fifo_tail_back), 32'd0);
      tick();
    end
    chk("wb.pops", 32'(pops - p0), 32'd4);

    // Single read at 0x2000.
    do_reset();
    mem[0] = ent(1'b1, 1'b1, 1'b0, 32'h2000, 32'h0);
    wr_cnt = 5'd1;
    drive(1, 1, 2'b00, 32'h0); tick();
    drive(1, 1, 2'b00, 32'h0); chk("rd.c1.readen", 32'(fifo_readen), 32'd1); tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("rd.c2.htrans", 32'(bus.HTRANS), 32'h2);
    chk("rd.c2.haddr", bus.HADDR, 32'h2000);
    chk("rd.c2.hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rd.c2.readen", 32'(fifo_readen), 32'd0);
    tick();
    drive(1, 1, 2'b00, 32'hDEAD_BEEF); chk("rd.c3.rdv", 32'(rd_valid), 32'd0); tick();
`ifdef AHB_MSEQ_RDATA_EN
    exp_rv = 1'b1; exp_rd = 32'hDEAD_BEEF;
`else
    exp_rv = 1'b0; exp_rd = 32'h0;
`endif
    drive(1, 1, 2'b00, 32'h0);
    chk("rd.c4.rdv", 32'(rd_valid), 32'(exp_rv));
    chk("rd.c4.rdd", rd_data, exp_rd);
    tick();
    drive(1, 1, 2'b00, 32'h0); chk("rd.c5.rdv", 32'(rd_valid), 32'd0); tick();

    // RETRY on beat 2 while beat 3 is in its address phase.
    do_reset();
    load_wburst();
    repeat (4) begin drive(1, 1, 2'b00, 32'h0); tick(); end
    drive(1, 0, 2'b10, 32'h0);
    chk("rty.c4.htrans", 32'(bus.HTRANS), 32'd0);
    chk("rty.c4.readen", 32'(fifo_readen), 32'd0);
    chk("rty.c4.tback", 32'(fifo_tail_back), 32'd0);
    tick();
    drive(1, 1, 2'b10, 32'h0);
    chk("rty.c5.tback", 32'(fifo_tail_back), 32'd1);
    chk("rty.c5.blen", 32'(fifo_back_length), 32'd2);
    chk("rty.c5.readen", 32'(fifo_readen), 32'd0);
    chk("rty.c5.htrans", 32'(bus.HTRANS), 32'd0);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("rty.c6.tback", 32'(fifo_tail_back), 32'd0);
    chk("rty.c6.readen", 32'(fifo_readen), 32'd1);
    chk("rty.c6.htrans", 32'(bus.HTRANS), 32'd0);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("rty.c7.htrans", 32'(bus.HTRANS), 32'h2);
    chk("rty.c7.haddr", bus.HADDR, 32'h1004);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("rty.c8.htrans", 32'(bus.HTRANS), 32'h3);
    chk("rty.c8.haddr", bus.HADDR, 32'h1008);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("rty.c9.haddr", bus.HADDR, 32'h100C);
    chk("rty.c9.hwdata", bus.HWDATA, 32'hA000_0003);
    tick();

    // ERROR on beat 1: one-cycle err_pulse, burst continues, no rewind.
    do_reset();
    load_wburst();
    repeat (3) begin drive(1, 1, 2'b00, 32'h0); tick(); end
    drive(1, 0, 2'b01, 32'h0);
    chk("err.c3.err", 32'(err_pulse), 32'd0);
    chk("err.c3.readen", 32'(fifo_readen), 32'd0);
    tick();
    drive(1, 1, 2'b01, 32'h0);
    chk("err.c4.err", 32'(err_pulse), 32'd1);
    chk("err.c4.tback", 32'(fifo_tail_back), 32'd0);
    chk("err.c4.htrans", 32'(bus.HTRANS), 32'h3);
    chk("err.c4.haddr", bus.HADDR, 32'h1004);
    chk("err.c4.readen", 32'(fifo_readen), 32'd1);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("err.c5.err", 32'(err_pulse), 32'd0);
    chk("err.c5.haddr", bus.HADDR, 32'h1008);
    chk("err.c5.tback", 32'(fifo_tail_back), 32'd0);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("err.c6.haddr", bus.HADDR, 32'h100C);
    chk("err.c6.htrans", 32'(bus.HTRANS), 32'h3);
    tick();

    // Grant lost after beat 2: beat 3 held and reissued as NONSEQ without an extra pop.
    do_reset();
    load_wburst();
    p0 = pops;
    repeat (4) begin drive(1, 1, 2'b00, 32'h0); tick(); end
    drive(0, 1, 2'b00, 32'h0); chk("gnt.c4.readen", 32'(fifo_readen), 32'd0); tick();
    drive(0, 1, 2'b00, 32'h0);
    chk("gnt.c5.htrans", 32'(bus.HTRANS), 32'd0);
    chk("gnt.c5.busreq", 32'(bus.HBUSREQ), 32'd1);
    chk("gnt.c5.readen", 32'(fifo_readen), 32'd0);
    tick();
    drive(1, 1, 2'b00, 32'h0); chk("gnt.c6.htrans", 32'(bus.HTRANS), 32'd0); tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("gnt.c7.htrans", 32'(bus.HTRANS), 32'h2);
    chk("gnt.c7.haddr", bus.HADDR, 32'h1008);
    tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("gnt.c8.htrans", 32'(bus.HTRANS), 32'h3);
    chk("gnt.c8.haddr", bus.HADDR, 32'h100C);
    tick();
    drive(1, 1, 2'b00, 32'h0); tick();
    chk("gnt.pops", 32'(pops - p0), 32'd4);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    load_wburst();
    repeat (3) begin drive(1, 1, 2'b00, 32'h0); tick(); end
    drive(1, 1, 2'b00, 32'h0);
    chk("mrst.pre.busy", 32'(busy), 32'd1);
    chk("mrst.pre.hwdata", bus.HWDATA, 32'hA000_0001);
    #1;
    HRESETn = 1'b0;
    wr_cnt  = 5'd0;
    #1;
    chk_reset("mrst");
    tick(); tick();
    HRESETn = 1'b1;
    tick(); tick();
    drive(1, 1, 2'b00, 32'h0);
    chk("mrst.post.busy", 32'(busy), 32'd0);
    chk("mrst.post.busreq", 32'(bus.HBUSREQ), 32'd0);
    chk("mrst.post.blen", 32'(fifo_back_length), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
